// File: rtl/sdram_cmd_initiator.sv
// sdram_cmd_initiator: runs the SDRAM config/init command sequence, then issues READA/WRITEA
// for user requests, holding each command until CMD_ACK or a bounded timeout.
module sdram_cmd_initiator #(
  parameter int               ASIZE          = 23,
  parameter logic [ASIZE-1:0] CFG_REG1       = 23'h000D25,
  parameter logic [ASIZE-1:0] CFG_REG2       = 23'h000600,
  parameter logic [ASIZE-1:0] MODE_WORD      = 23'h000023,
  parameter int               POWERUP_CYCLES = 100,
  parameter int               GAP_CYCLES     = 2,
  parameter int               ACK_TIMEOUT    = 255
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             USR_VALID,
  input  logic             USR_WRITE,
  input  logic [ASIZE-1:0] USR_ADDR,
  output logic             USR_READY,
  output logic             USR_DONE,
  output logic [2:0]       CMD,
  output logic [ASIZE-1:0] ADDR,
  input  logic             CMD_ACK,
  output logic             INIT_DONE,
  output logic             TIMEOUT_ERR,
  output logic             BUSY
);
  localparam int MAXC = (POWERUP_CYCLES > ACK_TIMEOUT) ?
                        ((POWERUP_CYCLES > GAP_CYCLES) ? POWERUP_CYCLES : GAP_CYCLES) :
                        ((ACK_TIMEOUT > GAP_CYCLES) ? ACK_TIMEOUT : GAP_CYCLES);
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {S_PWRUP, S_ISSUE, S_GAP, S_IDLE, S_ERR} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       step_q, step_d, cmd_q, cmd_d, init_cmd;
  logic [ASIZE-1:0] addr_q, addr_d, init_addr;
  logic             user_q, user_d, ready_q, ready_d, done_q, done_d;
  logic             init_q, init_d, terr_q, terr_d, busy_q;
  // init step table: REG1, REG2, PRECHARGE, REFRESH, REFRESH, MODE
  assign init_cmd  = step_q == 3'd0 ? 3'b110 : step_q == 3'd1 ? 3'b111 :
                     step_q == 3'd2 ? 3'b100 : step_q == 3'd5 ? 3'b101 : 3'b011;
  assign init_addr = step_q == 3'd0 ? CFG_REG1 : step_q == 3'd1 ? CFG_REG2 :
                     step_q == 3'd5 ? MODE_WORD : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    cmd_d   = cmd_q;
    addr_d  = addr_q;
    user_d  = user_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    init_d  = init_q;
    terr_d  = terr_q;
    case (state_q)
      S_PWRUP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(POWERUP_CYCLES - 1)) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          cmd_d   = init_cmd;
          addr_d  = init_addr;
          user_d  = 1'b0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + CW'(1);
        if (CMD_ACK) begin
          state_d = S_GAP;
          cnt_d   = '0;
          cmd_d   = 3'b000;
          done_d  = user_q;
          step_d  = user_q ? step_q : step_q + 3'd1;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERR;
          cmd_d   = 3'b000;
          terr_d  = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          cnt_d = '0;
          if (step_q < 3'd6) begin
            state_d = S_ISSUE;
            cmd_d   = init_cmd;
            addr_d  = init_addr;
            user_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            init_d  = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (USR_VALID && ready_q) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
          ready_d = 1'b0;
          cmd_d   = USR_WRITE ? 3'b010 : 3'b001;
          addr_d  = USR_ADDR;
          user_d  = 1'b1;
        end
      end
      default: begin
        cmd_d   = 3'b000;
        ready_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_PWRUP;
      cnt_q   <= '0;
      step_q  <= '0;
      cmd_q   <= '0;
      addr_q  <= '0;
      user_q  <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      init_q  <= 1'b0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      user_q  <= user_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      init_q  <= init_d;
      terr_q  <= terr_d;
      busy_q  <= cmd_d != 3'b000;
    end
  end
  assign USR_READY   = ready_q;
  assign USR_DONE    = done_q;
  assign CMD         = cmd_q;
  assign ADDR        = addr_q;
  assign INIT_DONE   = init_q;
  assign TIMEOUT_ERR = terr_q;
  assign BUSY        = busy_q;
endmodule

// File: tb/tb_sdram_cmd_initiator.sv
// tb_sdram_cmd_initiator: directed stimulus with a command scoreboard; a negedge monitor
// models the controller ack and checks each issued command against the expected queue.
module tb_sdram_cmd_initiator;
  logic        CLK = 0, RESET = 1, USR_VALID = 0, USR_WRITE = 0, CMD_ACK = 0;
  logic [22:0] USR_ADDR = '0, ADDR;
  logic [2:0]  CMD;
  logic        USR_READY, USR_DONE, INIT_DONE, TIMEOUT_ERR, BUSY;
  typedef struct { logic [2:0] c; logic [22:0] a; } exp_t;
  exp_t        exp_q[$];
  int          n_cmp = 0, n_bad = 0, done_cnt = 0;
  int          ack_dly = 2, nop_run = 0, cyc = 0;
  logic        ack_en = 1, force_ack = 0, first = 0, rst_seen = 0;
  logic [2:0]  noack_cmd = 3'b000, prev = 3'b000;
  logic [22:0] prev_addr = '0;

  sdram_cmd_initiator dut (
    .CLK(CLK), .RESET(RESET), .USR_VALID(USR_VALID), .USR_WRITE(USR_WRITE),
    .USR_ADDR(USR_ADDR), .USR_READY(USR_READY), .USR_DONE(USR_DONE), .CMD(CMD),
    .ADDR(ADDR), .CMD_ACK(CMD_ACK), .INIT_DONE(INIT_DONE), .TIMEOUT_ERR(TIMEOUT_ERR),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge CLK) rst_seen <= RESET;

  // monitor + controller model
  always @(negedge CLK) begin
    if (rst_seen) begin
      nop_run = 0;
      first = 1;
      prev = 3'b000;
      cyc = 0;
    end
    if (CMD != 3'b000 && prev == 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_cmd", {29'd0, CMD}, 32'd0);
      end else begin
        chk("cmd", {29'd0, CMD}, {29'd0, exp_q[0].c});
        chk("addr", {9'd0, ADDR}, {9'd0, exp_q[0].a});
        void'(exp_q.pop_front());
      end
      if (first) chk("pwrup_nops", nop_run, 100);
      else chk("gap_ge2", nop_run >= 2, 1);
      first = 0;
      cyc = 0;
      nop_run = 0;
    end else if (CMD != 3'b000) begin
      cyc++;
      chk("cmd_stable", {6'd0, CMD, ADDR}, {6'd0, prev, prev_addr});
    end else begin
      nop_run++;
    end
    chk("busy", BUSY, CMD != 3'b000);
    chk("ready_without_init", USR_READY & ~INIT_DONE, 0);
    if (USR_DONE) done_cnt++;
    prev = CMD;
    prev_addr = ADDR;
    CMD_ACK = force_ack || (ack_en && CMD != 3'b000 && CMD != noack_cmd && cyc == ack_dly);
  end

  task automatic push(input logic [2:0] c, input logic [22:0] a);
    exp_t e;
    e.c = c;
    e.a = a;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push(3'b110, 23'h000D25);
    push(3'b111, 23'h000600);
    push(3'b100, 23'h0);
    push(3'b011, 23'h0);
    push(3'b011, 23'h0);
    push(3'b101, 23'h000023);
  endtask

  task automatic wait_init();
    for (int i = 0; i < 2000 && !INIT_DONE; i++) @(negedge CLK);
    chk("init_done", INIT_DONE, 1);
    chk("ready_after_init", USR_READY, 1);
  endtask

  task automatic send(input logic w, input logic [22:0] a);
    USR_VALID = 1;
    USR_WRITE = w;
    USR_ADDR = a;
    for (int i = 0; i < 2000 && !USR_READY; i++) @(negedge CLK);
    chk("send_ready", USR_READY, 1);
    @(negedge CLK);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !USR_DONE; i++) @(negedge CLK);
    chk("done_pulse", USR_DONE, 1);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RESET = 0;
    chk("rst_cmd", {29'd0, CMD}, 0);
    chk("rst_addr", {9'd0, ADDR}, 0);
    chk("rst_flags", {USR_READY, USR_DONE, INIT_DONE, TIMEOUT_ERR, BUSY}, 0);
    push_init();
    wait_init();
    @(negedge CLK);
    chk("no_done_in_init", done_cnt, 0);

    ack_dly = 3;
    push(3'b010, 23'h012345);
    send(1, 23'h012345);
    USR_VALID = 0;
    chk("wr_cmd", {29'd0, CMD}, 32'd2);
    chk("wr_addr", {9'd0, ADDR}, 32'h012345);
    chk("wr_busy_ready", {BUSY, USR_READY}, 2'b10);
    wait_done(50);
    chk("wr_ack_cmd", {29'd0, CMD}, 0);
    @(negedge CLK);
    chk("wr_done_low_gap", {USR_DONE, USR_READY}, 0);
    @(negedge CLK);
    chk("wr_ready_back", USR_READY, 1);

    ack_dly = 2;
    push(3'b001, 23'h000010);
    push(3'b001, 23'h000020);
    send(0, 23'h000010);
    send(0, 23'h000020);
    USR_VALID = 0;
    for (int i = 0; i < 200 && done_cnt < 3; i++) @(negedge CLK);
    chk("b2b_done_cnt", done_cnt, 3);

    ack_dly = 254;
    push(3'b001, 23'h000030);
    send(0, 23'h000030);
    USR_VALID = 0;
    wait_done(600);
    chk("late_ack_no_err", TIMEOUT_ERR, 0);
    @(negedge CLK);
    chk("late_ack_done_cnt", done_cnt, 4);

    ack_dly = 2;
    ack_en = 0;
    push(3'b010, 23'h000040);
    send(1, 23'h000040);
    USR_VALID = 0;
    repeat (3) @(negedge CLK);
    chk("held_write", {29'd0, CMD}, 32'd2);
    RESET = 1;
    @(negedge CLK);
    RESET = 0;
    chk("midrst_cmd", {29'd0, CMD}, 0);
    chk("midrst_flags", {USR_READY, USR_DONE, INIT_DONE, TIMEOUT_ERR, BUSY}, 0);
    ack_en = 1;
    push_init();
    wait_init();
    @(negedge CLK);
    chk("midrst_no_done", done_cnt, 4);

    RESET = 1;
    noack_cmd = 3'b111;
    @(negedge CLK);
    RESET = 0;
    push(3'b110, 23'h000D25);
    push(3'b111, 23'h000600);
    for (int i = 0; i < 400 && CMD != 3'b111; i++) @(negedge CLK);
    begin
      int n;
      n = 0;
      while (CMD == 3'b111 && n < 400) begin
        n++;
        @(negedge CLK);
      end
      chk("timeout_hold", n, 255);
    end
    chk("to_cmd", {29'd0, CMD}, 0);
    chk("to_flags", {TIMEOUT_ERR, USR_READY, INIT_DONE}, 3'b100);
    USR_VALID = 1;
    force_ack = 1;
    repeat (3) @(negedge CLK);
    force_ack = 0;
    repeat (5) @(negedge CLK);
    USR_VALID = 0;
    chk("err_sticky", {TIMEOUT_ERR, USR_READY, BUSY, USR_DONE}, 4'b1000);
    chk("err_cmd", {29'd0, CMD}, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_initiator.md
Name: sdram_cmd_initiator

Overview:
Host-side command initiator for the SDR SDRAM controller command interface. After reset it drives CMD/ADDR through the mandatory configuration and initialisation sequence. It then turns a simple valid/ready user request stream into READA/WRITEA commands. Every command is held until the controller's single-cycle CMD_ACK pulse arrives, and each handshake is bounded by a timeout.

Parameters:
ASIZE, 23, width of ADDR/USR_ADDR (must be >= 16)
CFG_REG1, 23'h000D25, value driven on ADDR with LOAD_REG1 (CL/RC/RRD/PM/BL fields in bits 12:0)
CFG_REG2, 23'h000600, value driven on ADDR with LOAD_REG2 (refresh period in bits 15:0)
MODE_WORD, 23'h000023, value driven on ADDR with LOAD_MODE
POWERUP_CYCLES, 100, NOP cycles after reset before the first command (>= 1)
GAP_CYCLES, 2, minimum NOP cycles between an ack and the next command (>= 1)
ACK_TIMEOUT, 255, maximum cycles a command is held waiting for CMD_ACK (>= 4)

Ports:
CLK  input  1  system clock
RESET  input  1  synchronous reset, active-high
USR_VALID  input  1  user request valid
USR_WRITE  input  1  1 = write (WRITEA), 0 = read (READA)
USR_ADDR  input  ASIZE  user request address
USR_READY  output  1  request accepted when USR_VALID & USR_READY
USR_DONE  output  1  one-cycle pulse when a user command is acknowledged
CMD  output  3  command to controller: 000 NOP, 001 READA, 010 WRITEA, 011 REFRESH, 100 PRECHARGE, 101 LOAD_MODE, 110 LOAD_REG1, 111 LOAD_REG2
ADDR  output  ASIZE  address/config value accompanying CMD
CMD_ACK  input  1  single-cycle command acknowledge from controller
INIT_DONE  output  1  init sequence complete (sticky until reset)
TIMEOUT_ERR  output  1  sticky: a command was not acknowledged within ACK_TIMEOUT cycles
BUSY  output  1  a command is driven (CMD != 000)

Behaviour:
- One clock, CLK. Reset is synchronous and active-high (RESET). All outputs are registered.
- Reset values: CMD=000, ADDR=0, USR_READY=0, USR_DONE=0, INIT_DONE=0, TIMEOUT_ERR=0, BUSY=0. The FSM enters PWRUP and the step index is cleared to 0.
- States:
  - PWRUP: CMD=000. Counts POWERUP_CYCLES cycles, then goes to ISSUE with init step 0.
  - ISSUE: CMD/ADDR are driven and held stable. The timeout counter starts at 0 on the first cycle of the drive. CMD_ACK is sampled from that first cycle onward.
    - On CMD_ACK=1: at the next edge CMD=000, ADDR holds its last value, and the FSM goes to GAP. For user commands USR_DONE pulses in that same cycle.
    - If the counter reaches ACK_TIMEOUT with no ack: CMD=000, TIMEOUT_ERR=1, FSM goes to ERR.
  - GAP: CMD=000 for GAP_CYCLES cycles. It then goes to ISSUE with the next init step if any remain, otherwise to IDLE.
  - IDLE: USR_READY=1 (only when INIT_DONE=1). On USR_VALID & USR_READY at edge k:
    - USR_ADDR and USR_WRITE are latched, USR_READY drops at edge k.
    - CMD = 010 (write) or 001 (read) with ADDR = latched USR_ADDR, valid from cycle k+1. FSM goes to ISSUE.
  - ERR: CMD=000 and USR_READY=0 until reset; CMD_ACK is ignored.
- Init order, fixed, one handshake each:
  1. LOAD_REG1 / CFG_REG1
  2. LOAD_REG2 / CFG_REG2
  3. PRECHARGE / ADDR 0
  4. REFRESH / ADDR 0
  5. REFRESH / ADDR 0
  6. LOAD_MODE / MODE_WORD
  INIT_DONE rises when the GAP following the LOAD_MODE ack ends, in the same cycle USR_READY first rises.
- CMD_ACK seen in PWRUP, GAP, IDLE or ERR is ignored with no state change.
- CMD_ACK in the same cycle that the timeout count reaches ACK_TIMEOUT: the ack wins and no error is raised.
- USR_DONE is never asserted for init commands. Exactly one USR_DONE is produced per accepted request.
- CMD never changes while in ISSUE, and ADDR is stable whenever CMD != 000.
- RESET asserted mid-command: CMD=000 and all state is cleared at that edge. The full init sequence reruns, and a pending user request is dropped without USR_DONE.
- USR_VALID may drop without acceptance; there is no requirement to hold it.

Test Plan:
- Reset, then controller model acks each command 2 cycles after it is driven -> CMD=000 for exactly 100 cycles. Then 110(ADDR 000D25), 111(000600), 100, 011, 011, 101(000023), each followed by >=2 NOP cycles. INIT_DONE=1 and USR_READY=1 after the last GAP; USR_DONE stays 0.
- After init, USR_VALID=1, USR_WRITE=1, USR_ADDR=23'h012345 -> next cycle CMD=010, ADDR=012345, BUSY=1. Ack 3 cycles later -> CMD=000 and USR_DONE high for 1 cycle. USR_READY returns after 2 GAP cycles.
- Back-to-back reads at 000010 and 000020 with USR_VALID held high -> two separate 001 commands separated by >=2 NOP cycles, two USR_DONE pulses, and addresses in order.
- Model never acks LOAD_REG2 -> CMD=111 held 255 cycles, then CMD=000 and TIMEOUT_ERR=1. USR_READY stays 0; a later spurious CMD_ACK is ignored.
- Ack arrives exactly on cycle 255 of a READA -> USR_DONE=1 and TIMEOUT_ERR=0.
- RESET pulsed while CMD=010 is held -> CMD=000 the next cycle, no USR_DONE, INIT_DONE=0, and the 100-cycle PWRUP and full init sequence repeat.
